// File: rtl/rs_station.sv
// Unified reservation station: CDB wakeup, per-class FU issue select.
// Optional RS_OLDEST_FIRST_EN: age-based (oldest first) issue select.
module rs_station #(
  parameter int NUM_ENTRIES = 8,
  parameter int XLEN        = 32,
  parameter int TAG_W       = 5,
  parameter int NUM_FU      = 4,
  parameter int PAYLOAD_W   = 64,
  localparam int IDX_W      = $clog2(NUM_ENTRIES),
  localparam int FU_W       = $clog2(NUM_FU)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  input  logic [FU_W-1:0]      dispatch_fu,
  input  logic [TAG_W-1:0]     dispatch_t1,
  input  logic [TAG_W-1:0]     dispatch_t2,
  input  logic                 dispatch_r1,
  input  logic                 dispatch_r2,
  input  logic [XLEN-1:0]      dispatch_v1,
  input  logic [XLEN-1:0]      dispatch_v2,
  input  logic [TAG_W-1:0]     dispatch_dest,
  input  logic [PAYLOAD_W-1:0] dispatch_payload,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [XLEN-1:0]      cdb_value,
  input  logic [NUM_FU-1:0]    fu_ready,
  output logic                 issue_valid,
  output logic [FU_W-1:0]      issue_fu,
  output logic [XLEN-1:0]      issue_v1,
  output logic [XLEN-1:0]      issue_v2,
  output logic [TAG_W-1:0]     issue_dest,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic [IDX_W:0]       free_count
);

  logic [NUM_ENTRIES-1:0] e_valid, e_r1, e_r2;
  logic [FU_W-1:0]        e_fu   [NUM_ENTRIES];
  logic [TAG_W-1:0]       e_t1   [NUM_ENTRIES];
  logic [TAG_W-1:0]       e_t2   [NUM_ENTRIES];
  logic [XLEN-1:0]        e_v1   [NUM_ENTRIES];
  logic [XLEN-1:0]        e_v2   [NUM_ENTRIES];
  logic [TAG_W-1:0]       e_dest [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0]   e_pay  [NUM_ENTRIES];
`ifdef RS_OLDEST_FIRST_EN
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(NUM_ENTRIES - 1);
  logic [IDX_W-1:0]       e_age  [NUM_ENTRIES];
  logic [IDX_W-1:0]       best_age;
`endif

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W:0]   free_cnt;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [NUM_ENTRIES-1:0] cand;
  logic             accept;
  logic             d_r1, d_r2;
  logic [XLEN-1:0]  d_v1, d_v2;

  // Lowest free slot and free-entry count from registered state only.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    free_cnt   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!e_valid[i]) begin
        free_cnt = free_cnt + {{IDX_W{1'b0}}, 1'b1};
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign dispatch_ready = free_found;
  assign free_count     = free_cnt;
  assign accept         = dispatch_valid && free_found;

  // Dispatch-time bypass: capture an operand broadcast in the same cycle.
  always_comb begin
    d_r1 = dispatch_r1 || (cdb_valid && cdb_tag == dispatch_t1);
    d_r2 = dispatch_r2 || (cdb_valid && cdb_tag == dispatch_t2);
    d_v1 = dispatch_r1 ? dispatch_v1 : cdb_value;
    d_v2 = dispatch_r2 ? dispatch_v2 : cdb_value;
  end

  // Issue select among ready entries whose FU class can accept.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
    best_age  = '0;
`endif
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cand[i] = e_valid[i] && e_r1[i] && e_r2[i] && fu_ready[e_fu[i]];
`ifdef RS_OLDEST_FIRST_EN
      if (cand[i] && (!sel_found || e_age[i] > best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = e_age[i];
      end
`else
      if (cand[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
`endif
    end
  end

  // Drive issue bundle from the selected entry, zero when idle.
  always_comb begin
    issue_valid   = sel_found;
    issue_fu      = '0;
    issue_v1      = '0;
    issue_v2      = '0;
    issue_dest    = '0;
    issue_payload = '0;
    if (sel_found) begin
      issue_fu      = e_fu[sel_idx];
      issue_v1      = e_v1[sel_idx];
      issue_v2      = e_v2[sel_idx];
      issue_dest    = e_dest[sel_idx];
      issue_payload = e_pay[sel_idx];
    end
  end

  // Entry state: wakeup, aging, free on issue, write on dispatch, flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_valid <= '0;
      e_r1    <= '0;
      e_r2    <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        e_fu[i]   <= '0;
        e_t1[i]   <= '0;
        e_t2[i]   <= '0;
        e_v1[i]   <= '0;
        e_v2[i]   <= '0;
        e_dest[i] <= '0;
        e_pay[i]  <= '0;
`ifdef RS_OLDEST_FIRST_EN
        e_age[i]  <= '0;
`endif
      end
    end else if (flush) begin
      e_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (e_valid[i] && !e_r1[i] && cdb_valid && e_t1[i] == cdb_tag) begin
          e_r1[i] <= 1'b1;
          e_v1[i] <= cdb_value;
        end
        if (e_valid[i] && !e_r2[i] && cdb_valid && e_t2[i] == cdb_tag) begin
          e_r2[i] <= 1'b1;
          e_v2[i] <= cdb_value;
        end
`ifdef RS_OLDEST_FIRST_EN
        if (accept && e_valid[i] && e_age[i] != AGE_MAX)
          e_age[i] <= e_age[i] + 1'b1;
`endif
      end
      if (sel_found)
        e_valid[sel_idx] <= 1'b0;
      if (accept) begin
        e_valid[free_idx] <= 1'b1;
        e_fu[free_idx]    <= dispatch_fu;
        e_t1[free_idx]    <= dispatch_t1;
        e_t2[free_idx]    <= dispatch_t2;
        e_r1[free_idx]    <= d_r1;
        e_r2[free_idx]    <= d_r2;
        e_v1[free_idx]    <= d_v1;
        e_v2[free_idx]    <= d_v2;
        e_dest[free_idx]  <= dispatch_dest;
        e_pay[free_idx]   <= dispatch_payload;
`ifdef RS_OLDEST_FIRST_EN
        e_age[free_idx]   <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station with immediate-assertion checks.
// Covers reset, issue, wakeup, bypass, full, FU stall, select order, flush.
module tb_rs_station;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [1:0]  dispatch_fu;
  logic [4:0]  dispatch_t1, dispatch_t2;
  logic        dispatch_r1, dispatch_r2;
  logic [31:0] dispatch_v1, dispatch_v2;
  logic [4:0]  dispatch_dest;
  logic [63:0] dispatch_payload;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [3:0]  fu_ready;
  logic        issue_valid;
  logic [1:0]  issue_fu;
  logic [31:0] issue_v1, issue_v2;
  logic [4:0]  issue_dest;
  logic [63:0] issue_payload;
  logic [3:0]  free_count;

  int n_chk  = 0;
  int n_fail = 0;

  rs_station dut (
    .clock(clock), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_fu(dispatch_fu),
    .dispatch_t1(dispatch_t1), .dispatch_t2(dispatch_t2),
    .dispatch_r1(dispatch_r1), .dispatch_r2(dispatch_r2),
    .dispatch_v1(dispatch_v1), .dispatch_v2(dispatch_v2),
    .dispatch_dest(dispatch_dest), .dispatch_payload(dispatch_payload),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_fu(issue_fu),
    .issue_v1(issue_v1), .issue_v2(issue_v2),
    .issue_dest(issue_dest), .issue_payload(issue_payload),
    .free_count(free_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic disp(input logic [1:0] fu,
                      input logic [4:0] t1, input logic r1,
                      input logic [31:0] v1,
                      input logic [4:0] t2, input logic r2,
                      input logic [31:0] v2,
                      input logic [4:0] dest);
    dispatch_valid   = 1'b1;
    dispatch_fu      = fu;
    dispatch_t1      = t1;
    dispatch_r1      = r1;
    dispatch_v1      = v1;
    dispatch_t2      = t2;
    dispatch_r2      = r2;
    dispatch_v2      = v2;
    dispatch_dest    = dest;
    dispatch_payload = {32'hC0DE0000, 27'd0, dest};
  endtask

  task automatic bcast(input logic [4:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0;
    dispatch_fu = '0; dispatch_t1 = '0; dispatch_t2 = '0;
    dispatch_r1 = 1'b0; dispatch_r2 = 1'b0;
    dispatch_v1 = '0; dispatch_v2 = '0;
    dispatch_dest = '0; dispatch_payload = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    fu_ready = 4'b0000;
    #3;
    check("rst_free", free_count, 8);
    check("rst_ready", dispatch_ready, 1);
    check("rst_iv", issue_valid, 0);
    check("rst_v1", issue_v1, 0);
    check("rst_dest", issue_dest, 0);
    reset = 1'b0;

    // Basic dispatch and issue
    fu_ready = 4'b0001;
    disp(2'd0, 5'd0, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd1);
    tick();
    check("t1_iv", issue_valid, 1);
    check("t1_v1", issue_v1, 5);
    check("t1_v2", issue_v2, 7);
    check("t1_pay", issue_payload, 64'hC0DE0000_00000001);
    check("t1_free_busy", free_count, 7);
    tick();
    check("t1_free", free_count, 8);
    check("t1_iv_done", issue_valid, 0);

    // CDB wakeup one cycle after dispatch
    disp(2'd0, 5'd3, 1'b0, 32'd0, 5'd0, 1'b1, 32'd2, 5'd2);
    tick();
    check("t2_iv_wait", issue_valid, 0);
    bcast(5'd3, 32'hAA);
    #1;
    check("t2_iv_bcast", issue_valid, 0);
    tick();
    check("t2_iv", issue_valid, 1);
    check("t2_v1", issue_v1, 32'hAA);
    check("t2_v2", issue_v2, 2);
    tick();
    check("t2_free", free_count, 8);

    // Dispatch-time bypass
    disp(2'd0, 5'd0, 1'b1, 32'd1, 5'd9, 1'b0, 32'd0, 5'd3);
    bcast(5'd9, 32'h55);
    tick();
    check("t3_iv", issue_valid, 1);
    check("t3_v2", issue_v2, 32'h55);
    check("t3_dest", issue_dest, 3);
    tick();
    check("t3_free", free_count, 8);

    // Fill all entries, drop extra, wake one
    for (int i = 0; i < 8; i++) begin
      disp(2'd0, 5'(16 + i), 1'b0, 32'd0, 5'd0, 1'b1, 32'd0, 5'(i));
      tick();
    end
    check("t4_full_ready", dispatch_ready, 0);
    check("t4_full_free", free_count, 0);
    disp(2'd0, 5'd0, 1'b1, 32'd9, 5'd0, 1'b1, 32'd9, 5'd30);
    tick();
    check("t4_drop_free", free_count, 0);
    check("t4_drop_iv", issue_valid, 0);
    bcast(5'd19, 32'h33);
    tick();
    check("t4_wake_iv", issue_valid, 1);
    check("t4_wake_v1", issue_v1, 32'h33);
    check("t4_wake_dest", issue_dest, 3);
    tick();
    check("t4_free1", free_count, 1);
    check("t4_ready1", dispatch_ready, 1);
    flush = 1'b1;
    tick();
    check("t4_flush", free_count, 8);

    // LOAD held while its FU is busy
    fu_ready = 4'b0001;
    disp(2'd1, 5'd0, 1'b1, 32'h11, 5'd0, 1'b1, 32'h22, 5'd4);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t5_hold", issue_valid, 0);
      tick();
    end
    check("t5_held_free", free_count, 7);
    fu_ready = 4'b0011;
    #1;
    check("t5_iv", issue_valid, 1);
    check("t5_fu", issue_fu, 1);
    check("t5_v1", issue_v1, 32'h11);
    tick();
    check("t5_once", issue_valid, 0);
    check("t5_free", free_count, 8);

    // Select order: A in idx1, B in idx0 after idx0 frees
    fu_ready = 4'b0000;
    disp(2'd0, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd1);
    tick();
    disp(2'd2, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd10);
    tick();
    fu_ready = 4'b0001;
    tick();
    fu_ready = 4'b0000;
    check("t6_free_a", free_count, 7);
    disp(2'd2, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd11);
    tick();
    check("t6_free_ab", free_count, 6);
    fu_ready = 4'b0100;
    #1;
`ifdef RS_OLDEST_FIRST_EN
    check("t6_first", issue_dest, 10);
`else
    check("t6_first", issue_dest, 11);
`endif
    tick();
`ifdef RS_OLDEST_FIRST_EN
    check("t6_second", issue_dest, 11);
`else
    check("t6_second", issue_dest, 10);
`endif
    tick();
    check("t6_free", free_count, 8);

    // Flush overrides dispatch and issue
    fu_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      disp(2'd0, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'(i));
      tick();
    end
    check("fl_free4", free_count, 4);
    fu_ready = 4'b1111;
    disp(2'd0, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd20);
    flush = 1'b1;
    #1;
    check("fl_iv_comb", issue_valid, 1);
    tick();
    check("fl_free", free_count, 8);
    check("fl_iv", issue_valid, 0);

    // Async reset mid-cycle
    fu_ready = 4'b0000;
    disp(2'd0, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd5);
    tick();
    disp(2'd0, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd6);
    tick();
    check("ar_free2", free_count, 6);
    #2;
    reset = 1'b1;
    #1;
    check("ar_free", free_count, 8);
    check("ar_ready", dispatch_ready, 1);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
